// File: rtl/ysyx_25030093_ifu_if.sv
// Signal bundle between the instruction fetch unit, the PC register, the read bus and decode.
// The master modport is the fetch unit's view; slave is everything around it.
interface ysyx_25030093_ifu_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc_in;
  logic             next_fetch;
  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    input  pc_in, next_fetch, arready, rdata, rresp, rvalid, inst_ready,
    output araddr, arvalid, rready, inst, inst_pc, inst_valid, fault_code, fetch_cnt
  );

  modport slave (
    output pc_in, next_fetch, arready, rdata, rresp, rvalid, inst_ready,
    input  araddr, arvalid, rready, inst, inst_pc, inst_valid, fault_code, fetch_cnt
  );
endinterface

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: reads the word at pc_in over the valid/ready bus, holds it for decode,
// and waits for the PC register to advance. Flags misaligned, bus-error and timeout fetches.
module ysyx_25030093_ifu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic                clk,
  input logic                rst,
  ysyx_25030093_ifu_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT,
    S_WAIT
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [31:0]      timer;
  logic [31:0]      araddr_q;
  logic [31:0]      inst_q;
  logic [31:0]      inst_pc_q;
  logic [1:0]       fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic             misaligned;
  logic             ar_done;
  logic             r_done;
  logic             expired;

  assign misaligned = (bus.pc_in[1:0] != 2'b00);
  assign ar_done    = (state == S_AR) && bus.arready;
  assign r_done     = (state == S_R) && bus.rvalid;
  // ">=" keeps the watchdog alive after an address handshake that won on the final cycle
  assign expired    = (TIMEOUT != 0) && ((state == S_AR) || (state == S_R)) && (timer >= TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = misaligned ? S_OUT : S_AR;
      S_AR: begin
        if (ar_done)      state_next = S_R;
        else if (expired) state_next = S_OUT;
      end
      S_R: begin
        if (r_done || expired) state_next = S_OUT;
      end
      S_OUT:  if (bus.inst_ready) state_next = S_WAIT;
      S_WAIT: if (bus.next_fetch) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.arvalid    = (state == S_AR);
    bus.rready     = (state == S_R);
    bus.inst_valid = (state == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q  <= '0;
      inst_pc_q <= '0;
      inst_q    <= '0;
      fault_q   <= 2'b00;
      cnt_q     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          araddr_q  <= bus.pc_in;
          inst_pc_q <= bus.pc_in;
          timer     <= '0;
          if (misaligned) begin
            inst_q  <= '0;
            fault_q <= 2'b01;
          end
        end
        S_AR, S_R: begin
          timer <= timer + 32'd1;
          if (r_done) begin
            inst_q  <= bus.rdata;
            fault_q <= (bus.rresp != 2'b00) ? 2'b10 : 2'b00;
          end else if (expired && !ar_done) begin
            inst_q  <= '0;
            fault_q <= 2'b11;
          end
        end
        S_OUT: begin
          if (bus.inst_ready) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.araddr     = araddr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fault_code = fault_q;
  assign bus.fetch_cnt  = cnt_q;

endmodule
